id_ex_stage_reg: RTL and testbench

- Pipeline register between the instruction-decode stage and the execute stage of the ARM core.
- Captures the two operand values read from the register file in decode, plus decoded control, immediate and shift fields, destination, source addresses and the status flags.
- Presents all captured fields to execute for exactly one instruction per accepted cycle.
- Implements hold (memory-stage wait), flush (taken branch) and a pending-flush latch so that a flush raised during a hold is never lost.

---
 rtl/id_ex_stage_reg_pkg.sv | 25 ++
 rtl/id_ex_stage_reg_pipe_reg.sv | 26 ++
 rtl/id_ex_stage_reg.sv | 117 +++++++++++
 tb/tb_id_ex_stage_reg.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_reg_pkg.sv
// Shared widths and field-group types for the ID/EX pipeline register.
// Fields are grouped so that each group maps onto one pipe_reg instance.
package id_ex_stage_reg_pkg;

   localparam int REGISTER_LEN      = 32;
   localparam int REG_ADDRESS_LEN   = 4;
   localparam int EXE_CMD_LEN       = 4;
   localparam int SHIFT_OPERAND_LEN = 12;
   localparam int IMM24_LEN         = 24;
   localparam int STATUS_LEN        = 4;

   localparam int DATA_W = 3*REGISTER_LEN + EXE_CMD_LEN + SHIFT_OPERAND_LEN + IMM24_LEN;
   localparam int ADDR_W = 3*REG_ADDRESS_LEN;

   typedef struct packed {
      logic valid;
      logic wbEn;
      logic memREn;
      logic memWEn;
      logic b;
      logic s;
      logic imm;
   } ctrl_t;

endpackage

// File: rtl/id_ex_stage_reg_pipe_reg.sv
// Parameterised enable/clear register with asynchronous active-low reset.
// Clear only takes effect on an enabled edge, so a held register ignores it.
module pipe_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en_i,
   input  logic         clr_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] data_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_q <= '0;
      end else if (en_i) begin
         data_q <= clr_i ? '0 : d_i;
      end
   end

   assign q_o = data_q;

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: hold, flush-to-bubble, and a pending-flush latch
// that remembers a flush seen while the stage is held.
module id_ex_stage_reg
   import id_ex_stage_reg_pkg::*;
(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         hold,
   input  logic                         flush,
   input  logic                         valid_in,
   input  logic [REGISTER_LEN-1:0]      pc_in,
   input  logic                         wb_en_in,
   input  logic                         mem_r_en_in,
   input  logic                         mem_w_en_in,
   input  logic                         b_in,
   input  logic                         s_in,
   input  logic                         imm_in,
   input  logic [EXE_CMD_LEN-1:0]       exe_cmd_in,
   input  logic [REGISTER_LEN-1:0]      val_rn_in,
   input  logic [REGISTER_LEN-1:0]      val_rm_in,
   input  logic [SHIFT_OPERAND_LEN-1:0] shift_operand_in,
   input  logic [IMM24_LEN-1:0]         signed_imm_24_in,
   input  logic [REG_ADDRESS_LEN-1:0]   dest_in,
   input  logic [REG_ADDRESS_LEN-1:0]   src1_in,
   input  logic [REG_ADDRESS_LEN-1:0]   src2_in,
   input  logic [STATUS_LEN-1:0]        status_in,
   output logic                         valid_out,
   output logic [REGISTER_LEN-1:0]      pc_out,
   output logic                         wb_en_out,
   output logic                         mem_r_en_out,
   output logic                         mem_w_en_out,
   output logic                         b_out,
   output logic                         s_out,
   output logic                         imm_out,
   output logic [EXE_CMD_LEN-1:0]       exe_cmd_out,
   output logic [REGISTER_LEN-1:0]      val_rn_out,
   output logic [REGISTER_LEN-1:0]      val_rm_out,
   output logic [SHIFT_OPERAND_LEN-1:0] shift_operand_out,
   output logic [IMM24_LEN-1:0]         signed_imm_24_out,
   output logic [REG_ADDRESS_LEN-1:0]   dest_out,
   output logic [REG_ADDRESS_LEN-1:0]   src1_out,
   output logic [REG_ADDRESS_LEN-1:0]   src2_out,
   output logic [STATUS_LEN-1:0]        status_out,
   output logic                         flush_pending
);

   logic              loadEn;
   logic              bubble;
   logic              flushPending_d, flushPending_q;
   ctrl_t             ctrl_d, ctrl_q;
   logic [DATA_W-1:0] data_d, data_q;
   logic [ADDR_W-1:0] addr_d, addr_q;

   assign loadEn = ~hold;
   assign bubble = flush | flushPending_q;

   // An invalid instruction must never carry live control into execute.
   always_comb begin
      ctrl_d       = '0;
      ctrl_d.valid = valid_in;
      if (valid_in) begin
         ctrl_d.wbEn   = wb_en_in;
         ctrl_d.memREn = mem_r_en_in;
         ctrl_d.memWEn = mem_w_en_in;
         ctrl_d.b      = b_in;
         ctrl_d.s      = s_in;
         ctrl_d.imm    = imm_in;
      end
   end

   assign data_d = {pc_in, exe_cmd_in, val_rn_in, val_rm_in, shift_operand_in, signed_imm_24_in};
   assign addr_d = {dest_in, src1_in, src2_in};

   always_comb begin
      flushPending_d = flushPending_q;
      if (hold) begin
         if (flush) flushPending_d = 1'b1;
      end else begin
         flushPending_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) flushPending_q <= 1'b0;
      else      flushPending_q <= flushPending_d;
   end

   pipe_reg #(.W($bits(ctrl_t))) uCtrl (
      .clk(clk), .rst(rst), .en_i(loadEn), .clr_i(bubble), .d_i(ctrl_d), .q_o(ctrl_q)
   );

   pipe_reg #(.W(DATA_W)) uData (
      .clk(clk), .rst(rst), .en_i(loadEn), .clr_i(bubble), .d_i(data_d), .q_o(data_q)
   );

   pipe_reg #(.W(ADDR_W)) uAddr (
      .clk(clk), .rst(rst), .en_i(loadEn), .clr_i(bubble), .d_i(addr_d), .q_o(addr_q)
   );

   pipe_reg #(.W(STATUS_LEN)) uStatus (
      .clk(clk), .rst(rst), .en_i(loadEn), .clr_i(bubble), .d_i(status_in), .q_o(status_out)
   );

   assign valid_out    = ctrl_q.valid;
   assign wb_en_out    = ctrl_q.wbEn;
   assign mem_r_en_out = ctrl_q.memREn;
   assign mem_w_en_out = ctrl_q.memWEn;
   assign b_out        = ctrl_q.b;
   assign s_out        = ctrl_q.s;
   assign imm_out      = ctrl_q.imm;

   assign {pc_out, exe_cmd_out, val_rn_out, val_rm_out, shift_operand_out, signed_imm_24_out} = data_q;
   assign {dest_out, src1_out, src2_out} = addr_q;

   assign flush_pending = flushPending_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg: directed test-plan scenarios
// followed by randomized traffic against a behavioural model.
module tb_id_ex_stage_reg;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        hold = 0, flush = 0, valid_in = 0;
   logic [31:0] pc_in = 0;
   logic        wb_en_in = 0, mem_r_en_in = 0, mem_w_en_in = 0, b_in = 0, s_in = 0, imm_in = 0;
   logic [3:0]  exe_cmd_in = 0;
   logic [31:0] val_rn_in = 0, val_rm_in = 0;
   logic [11:0] shift_operand_in = 0;
   logic [23:0] signed_imm_24_in = 0;
   logic [3:0]  dest_in = 0, src1_in = 0, src2_in = 0, status_in = 0;

   logic        valid_out, wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, imm_out, flush_pending;
   logic [31:0] pc_out, val_rn_out, val_rm_out;
   logic [3:0]  exe_cmd_out, dest_out, src1_out, src2_out, status_out;
   logic [11:0] shift_operand_out;
   logic [23:0] signed_imm_24_out;

   // Expected architectural state of the stage register.
   logic        eValid, eWb, eMr, eMw, eB, eS, eImm, ePending;
   logic [31:0] ePc, eRn, eRm;
   logic [3:0]  eCmd, eDest, eSrc1, eSrc2, eStatus;
   logic [11:0] eShift;
   logic [23:0] eImm24;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   id_ex_stage_reg dut (
      .clk(clk), .rst(rst), .hold(hold), .flush(flush), .valid_in(valid_in), .pc_in(pc_in),
      .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
      .b_in(b_in), .s_in(s_in), .imm_in(imm_in), .exe_cmd_in(exe_cmd_in),
      .val_rn_in(val_rn_in), .val_rm_in(val_rm_in), .shift_operand_in(shift_operand_in),
      .signed_imm_24_in(signed_imm_24_in), .dest_in(dest_in), .src1_in(src1_in),
      .src2_in(src2_in), .status_in(status_in),
      .valid_out(valid_out), .pc_out(pc_out), .wb_en_out(wb_en_out),
      .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out), .b_out(b_out),
      .s_out(s_out), .imm_out(imm_out), .exe_cmd_out(exe_cmd_out),
      .val_rn_out(val_rn_out), .val_rm_out(val_rm_out), .shift_operand_out(shift_operand_out),
      .signed_imm_24_out(signed_imm_24_out), .dest_out(dest_out), .src1_out(src1_out),
      .src2_out(src2_out), .status_out(status_out), .flush_pending(flush_pending)
   );

   // Single comparison point: counts the check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic clearModel();
      {eValid, eWb, eMr, eMw, eB, eS, eImm, ePending} = '0;
      {ePc, eRn, eRm, eCmd, eDest, eSrc1, eSrc2, eStatus, eShift, eImm24} = '0;
   endtask

   // Behavioural rule set applied once per rising edge.
   task automatic modelEdge();
      if (!rst) begin
         clearModel();
      end else if (hold) begin
         if (flush) ePending = 1'b1;
      end else if (flush || ePending) begin
         clearModel();
      end else begin
         eValid = valid_in;
         eWb = valid_in & wb_en_in;   eMr = valid_in & mem_r_en_in;
         eMw = valid_in & mem_w_en_in; eB = valid_in & b_in;
         eS = valid_in & s_in;         eImm = valid_in & imm_in;
         ePc = pc_in; eRn = val_rn_in; eRm = val_rm_in; eCmd = exe_cmd_in;
         eShift = shift_operand_in; eImm24 = signed_imm_24_in;
         eDest = dest_in; eSrc1 = src1_in; eSrc2 = src2_in; eStatus = status_in;
      end
   endtask

   task automatic checkAll(input string tag);
      checkOutput({tag, ".valid"}, 32'(valid_out), 32'(eValid));
      checkOutput({tag, ".ctrl"}, 32'({wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, imm_out}),
                  32'({eWb, eMr, eMw, eB, eS, eImm}));
      checkOutput({tag, ".pc"}, pc_out, ePc);
      checkOutput({tag, ".rn"}, val_rn_out, eRn);
      checkOutput({tag, ".rm"}, val_rm_out, eRm);
      checkOutput({tag, ".cmd"}, 32'(exe_cmd_out), 32'(eCmd));
      checkOutput({tag, ".shift"}, 32'(shift_operand_out), 32'(eShift));
      checkOutput({tag, ".imm24"}, 32'(signed_imm_24_out), 32'(eImm24));
      checkOutput({tag, ".addr"}, 32'({dest_out, src1_out, src2_out}), 32'({eDest, eSrc1, eSrc2}));
      checkOutput({tag, ".status"}, 32'(status_out), 32'(eStatus));
      checkOutput({tag, ".pending"}, 32'(flush_pending), 32'(ePending));
   endtask

   task automatic randomizeData();
      valid_in = 1'($urandom); pc_in = $urandom;
      {wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in} = 6'($urandom);
      exe_cmd_in = 4'($urandom); val_rn_in = $urandom; val_rm_in = $urandom;
      shift_operand_in = 12'($urandom); signed_imm_24_in = 24'($urandom);
      {dest_in, src1_in, src2_in, status_in} = 16'($urandom);
   endtask

   // Inputs are set just after a falling edge; the edge is then taken and checked.
   task automatic applyStimulus(input string tag);
      @(posedge clk);
      modelEdge();
      @(negedge clk);
      checkAll(tag);
   endtask

   initial begin
      clearModel();
      @(negedge clk); @(negedge clk);
      checkAll("reset");
      rst = 1'b1;

      // Reset mid-operation must clear outputs without a clock edge.
      hold = 0; flush = 0; valid_in = 1; wb_en_in = 1; val_rn_in = 32'hDEADBEEF;
      applyStimulus("preReset");
      #2 rst = 1'b0;
      #1 clearModel();
      checkAll("asyncReset");
      @(negedge clk); rst = 1'b1;

      randomizeData();
      valid_in = 1; pc_in = 32'h10; dest_in = 4'd5; val_rm_in = 32'h7; exe_cmd_in = 4'b0010;
      applyStimulus("normalLoad");

      flush = 1; valid_in = 1; wb_en_in = 1;
      applyStimulus("flush");
      flush = 0; randomizeData(); valid_in = 1;
      applyStimulus("afterFlush");

      for (int i = 0; i < 3; i++) begin
         randomizeData(); hold = 1; flush = (i == 1);
         applyStimulus("hold");
      end
      hold = 0; flush = 0; randomizeData();
      applyStimulus("pendingBubble");
      randomizeData(); valid_in = 1;
      applyStimulus("afterBubble");

      randomizeData(); valid_in = 0; mem_w_en_in = 1; wb_en_in = 1;
      applyStimulus("invalidIn");

      for (int i = 0; i < 3; i++) begin
         randomizeData(); flush = 1;
         applyStimulus("flushRun");
      end
      flush = 0;

      randomizeData(); hold = 1; flush = 1;
      applyStimulus("setPending");
      flush = 0;
      #2 rst = 1'b0;
      #1 clearModel();
      checkAll("resetPending");
      @(negedge clk); rst = 1'b1; hold = 0;
      randomizeData(); valid_in = 1;
      applyStimulus("postResetLoad");

      for (int i = 0; i < 400; i++) begin
         randomizeData();
         hold = ($urandom_range(0, 3) == 0);
         flush = ($urandom_range(0, 4) == 0);
         applyStimulus("random");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
